// File: rtl/rob_param_queue_if.sv
// Handshake/bus bundle for rob_param_queue: dispatch, writeback, operand lookup and commit.
// slave = the reorder buffer, master = the surrounding pipeline.
interface rob_param_queue_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = $clog2(DEPTH + 1),
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned RD_W   = 5
);
  logic                     disp_valid;
  logic                     disp_ready;
  logic [OP_W-1:0]          disp_op;
  logic [RD_W-1:0]          disp_rd;
  logic [XLEN-1:0]          disp_imm;
  logic                     disp_done;
  logic [TAG_W-1:0]         disp_tag;
  logic                     flush;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*XLEN-1:0]   wb_value;
  logic [NUM_WB-1:0]        wb_flag;
  logic [TAG_W-1:0]         src1_tag;
  logic [TAG_W-1:0]         src2_tag;
  logic                     src1_ready;
  logic [XLEN-1:0]          src1_value;
  logic                     src2_ready;
  logic [XLEN-1:0]          src2_value;
  logic                     commit_valid;
  logic [TAG_W-1:0]         commit_tag;
  logic [OP_W-1:0]          commit_op;
  logic [RD_W-1:0]          commit_rd;
  logic [XLEN-1:0]          commit_value;
  logic                     commit_flag;
  logic [TAG_W-1:0]         count;
  logic                     full;
  logic                     empty;

  modport slave (
    input  disp_valid, disp_op, disp_rd, disp_imm, disp_done, flush,
           wb_valid, wb_tag, wb_value, wb_flag, src1_tag, src2_tag,
    output disp_ready, disp_tag, src1_ready, src1_value, src2_ready, src2_value,
           commit_valid, commit_tag, commit_op, commit_rd, commit_value, commit_flag,
           count, full, empty
  );

  modport master (
    output disp_valid, disp_op, disp_rd, disp_imm, disp_done, flush,
           wb_valid, wb_tag, wb_value, wb_flag, src1_tag, src2_tag,
    input  disp_ready, disp_tag, src1_ready, src1_value, src2_ready, src2_value,
           commit_valid, commit_tag, commit_op, commit_rd, commit_value, commit_flag,
           count, full, empty
  );
endinterface

// File: rtl/rob_param_queue.sv
// Reorder buffer: circular queue of DEPTH entries tagged 1..DEPTH (tag 0 = register file).
// Define ROB_WB_BYPASS_EN to let operand lookup see same-cycle writebacks.
module rob_param_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = $clog2(DEPTH + 1),
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned RD_W   = 5
) (
  input logic              clk,
  input logic              rst,
  rob_param_queue_if.slave bus
);
  logic [DEPTH:1]   busy_q, busy_d, done_q, done_d, flag_q, flag_d;
  logic [XLEN-1:0]  val_q [1:DEPTH];
  logic [XLEN-1:0]  val_d [1:DEPTH];
  logic [OP_W-1:0]  op_q  [1:DEPTH];
  logic [OP_W-1:0]  op_d  [1:DEPTH];
  logic [RD_W-1:0]  rd_q  [1:DEPTH];
  logic [RD_W-1:0]  rd_d  [1:DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic             cvalid_q, cvalid_d, cflag_q, cflag_d;
  logic [TAG_W-1:0] ctag_q, ctag_d;
  logic [OP_W-1:0]  cop_q, cop_d;
  logic [RD_W-1:0]  crd_q, crd_d;
  logic [XLEN-1:0]  cval_q, cval_d;

  logic             accept, commit_fire;
  logic             h_busy, h_done, h_flag;
  logic [OP_W-1:0]  h_op;
  logic [RD_W-1:0]  h_rd;
  logic [XLEN-1:0]  h_val;

  function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] t);
    return (t == TAG_W'(DEPTH)) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction

  assign bus.disp_ready   = (count_q < TAG_W'(DEPTH));
  assign bus.disp_tag     = tail_q;
  assign bus.full         = (count_q == TAG_W'(DEPTH));
  assign bus.empty        = (count_q == '0);
  assign bus.count        = count_q;
  assign bus.commit_valid = cvalid_q;
  assign bus.commit_tag   = ctag_q;
  assign bus.commit_op    = cop_q;
  assign bus.commit_rd    = crd_q;
  assign bus.commit_value = cval_q;
  assign bus.commit_flag  = cflag_q;

  assign accept = bus.disp_valid && bus.disp_ready;

  always_comb begin
    h_busy = 1'b0;
    h_done = 1'b0;
    h_flag = 1'b0;
    h_op   = '0;
    h_rd   = '0;
    h_val  = '0;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      if (head_q == TAG_W'(i)) begin
        h_busy = busy_q[i];
        h_done = done_q[i];
        h_flag = flag_q[i];
        h_op   = op_q[i];
        h_rd   = rd_q[i];
        h_val  = val_q[i];
      end
    end
  end

  assign commit_fire = h_busy && h_done;

  // Per-entry order: writebacks (higher port wins), commit clear, then dispatch.
  // Writebacks test pre-edge busy, so a same-cycle write to the new tail is dropped.
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    flag_d = flag_q;
    val_d  = val_q;
    op_d   = op_q;
    rd_d   = rd_q;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (bus.wb_valid[k] && busy_q[i] &&
            (bus.wb_tag[k*TAG_W +: TAG_W] == TAG_W'(i))) begin
          val_d[i]  = bus.wb_value[k*XLEN +: XLEN];
          flag_d[i] = bus.wb_flag[k];
          done_d[i] = 1'b1;
        end
      end
      if (commit_fire && (head_q == TAG_W'(i))) busy_d[i] = 1'b0;
      if (accept && (tail_q == TAG_W'(i))) begin
        busy_d[i] = 1'b1;
        done_d[i] = bus.disp_done;
        flag_d[i] = 1'b0;
        op_d[i]   = bus.disp_op;
        rd_d[i]   = bus.disp_rd;
        val_d[i]  = bus.disp_imm;
      end
    end

    head_d   = commit_fire ? wrap_inc(head_q) : head_q;
    tail_d   = accept ? wrap_inc(tail_q) : tail_q;
    count_d  = count_q + TAG_W'(accept) - TAG_W'(commit_fire);
    cvalid_d = commit_fire;
    ctag_d   = commit_fire ? head_q : ctag_q;
    cop_d    = commit_fire ? h_op   : cop_q;
    crd_d    = commit_fire ? h_rd   : crd_q;
    cval_d   = commit_fire ? h_val  : cval_q;
    cflag_d  = commit_fire ? h_flag : cflag_q;

    if (bus.flush) begin
      busy_d   = '0;
      done_d   = '0;
      head_d   = TAG_W'(1);
      tail_d   = TAG_W'(1);
      count_d  = '0;
      cvalid_d = 1'b0;
      ctag_d   = ctag_q;
      cop_d    = cop_q;
      crd_d    = crd_q;
      cval_d   = cval_q;
      cflag_d  = cflag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      done_q   <= '0;
      flag_q   <= '0;
      head_q   <= TAG_W'(1);
      tail_q   <= TAG_W'(1);
      count_q  <= '0;
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      cop_q    <= '0;
      crd_q    <= '0;
      cval_q   <= '0;
      cflag_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      flag_q   <= flag_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cvalid_q <= cvalid_d;
      ctag_q   <= ctag_d;
      cop_q    <= cop_d;
      crd_q    <= crd_d;
      cval_q   <= cval_d;
      cflag_q  <= cflag_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    op_q  <= op_d;
    rd_q  <= rd_d;
  end

  logic [1:0][TAG_W-1:0] src_tag;
  logic [1:0]            src_rdy;
  logic [1:0][XLEN-1:0]  src_val;

  assign src_tag        = {bus.src2_tag, bus.src1_tag};
  assign bus.src1_ready = src_rdy[0];
  assign bus.src1_value = src_val[0];
  assign bus.src2_ready = src_rdy[1];
  assign bus.src2_value = src_val[1];

  always_comb begin
    src_rdy = '0;
    src_val = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      if (src_tag[s] == '0) begin
        src_rdy[s] = 1'b1;
      end else begin
        for (int unsigned i = 1; i <= DEPTH; i++) begin
          if ((src_tag[s] == TAG_W'(i)) && busy_q[i] && done_q[i]) begin
            src_rdy[s] = 1'b1;
            src_val[s] = val_q[i];
          end
        end
`ifdef ROB_WB_BYPASS_EN
        for (int unsigned k = 0; k < NUM_WB; k++) begin
          if (bus.wb_valid[k] && (bus.wb_tag[k*TAG_W +: TAG_W] == src_tag[s])) begin
            src_rdy[s] = 1'b1;
            src_val[s] = bus.wb_value[k*XLEN +: XLEN];
          end
        end
`else
`endif
      end
    end
  end
endmodule

// File: tb/tb_rob_param_queue.sv
// Directed vector bench for rob_param_queue (DEPTH=8, two writeback ports).
module tb_rob_param_queue;
`ifdef ROB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_param_queue_if #(.DEPTH(8), .TAG_W(4), .XLEN(32), .NUM_WB(2), .OP_W(5), .RD_W(5)) bus ();

  rob_param_queue #(.DEPTH(8), .TAG_W(4), .XLEN(32), .NUM_WB(2), .OP_W(5), .RD_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        dv, dd, fl;
    logic [31:0] imm;
    logic [1:0]  wbv, wf;
    logic [3:0]  wt0, wt1;
    logic [31:0] wv0, wv1;
    logic [3:0]  s1;
    logic [3:0]  e_dtag;
    logic        e_sr;
    logic [31:0] e_sv;
    logic [3:0]  e_cnt;
    logic        e_cv;
    logic [3:0]  e_ctag;
    logic [31:0] e_cval;
    logic        e_cf;
  } vec_t;

  vec_t tv [18];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
      input logic dv, input logic dd, input logic [31:0] imm,
      input logic [1:0] wbv, input logic [3:0] wt0, input logic [31:0] wv0,
      input logic [3:0] wt1, input logic [31:0] wv1, input logic [1:0] wf,
      input logic [3:0] s1, input logic [3:0] e_dtag, input logic e_sr, input logic [31:0] e_sv,
      input logic [3:0] e_cnt, input logic e_cv, input logic [3:0] e_ctag,
      input logic [31:0] e_cval, input logic e_cf);
    vec_t v;
    v.dv = dv; v.dd = dd; v.fl = 1'b0; v.imm = imm;
    v.wbv = wbv; v.wt0 = wt0; v.wv0 = wv0; v.wt1 = wt1; v.wv1 = wv1; v.wf = wf;
    v.s1 = s1; v.e_dtag = e_dtag; v.e_sr = e_sr; v.e_sv = e_sv;
    v.e_cnt = e_cnt; v.e_cv = e_cv; v.e_ctag = e_ctag; v.e_cval = e_cval; v.e_cf = e_cf;
    return v;
  endfunction

  task automatic idle();
    bus.disp_valid = 1'b0; bus.disp_done = 1'b0; bus.disp_imm = '0;
    bus.disp_op = '0; bus.disp_rd = '0; bus.flush = 1'b0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_value = '0; bus.wb_flag = '0;
    bus.src1_tag = '0; bus.src2_tag = '0;
  endtask

  task automatic apply(input vec_t v);
    bus.disp_valid = v.dv; bus.disp_done = v.dd; bus.disp_imm = v.imm;
    bus.disp_op = v.imm[4:0]; bus.disp_rd = v.imm[9:5]; bus.flush = v.fl;
    bus.wb_valid = v.wbv; bus.wb_tag = {v.wt1, v.wt0};
    bus.wb_value = {v.wv1, v.wv0}; bus.wb_flag = v.wf;
    bus.src1_tag = v.s1; bus.src2_tag = v.s1;
  endtask

  task automatic dispatch(input logic [31:0] imm, input logic [4:0] op, input logic [4:0] rd);
    bus.disp_valid = 1'b1; bus.disp_done = 1'b0; bus.disp_imm = imm;
    bus.disp_op = op; bus.disp_rd = rd;
  endtask

  task automatic wb0(input logic [3:0] tag, input logic [31:0] val);
    bus.wb_valid = 2'b01; bus.wb_tag = {4'd0, tag}; bus.wb_value = {32'd0, val};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //   dv dd imm       wbv   t0 v0       t1 v1   wf    s1 | dtag rdy val | cnt cv ctag cval cf
    tv[0]  = mk(1, 0, 32'h10, 2'b00, 0, 0,        0, 0,      2'b00, 0, 1, 1, 0,                 1, 0, 0, 0, 0);
    tv[1]  = mk(1, 0, 32'h20, 2'b00, 0, 0,        0, 0,      2'b00, 0, 2, 1, 0,                 2, 0, 0, 0, 0);
    tv[2]  = mk(1, 0, 32'h30, 2'b00, 0, 0,        0, 0,      2'b00, 0, 3, 1, 0,                 3, 0, 0, 0, 0);
    tv[3]  = mk(0, 0, 0,      2'b01, 2, 32'h55,   0, 0,      2'b00, 2, 4, BYP, BYP ? 32'h55 : 32'h0, 3, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 0,      2'b01, 1, 32'hAA,   0, 0,      2'b00, 2, 4, 1, 32'h55,            3, 0, 0, 0, 0);
    tv[5]  = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 1, 4, 1, 32'hAA,            2, 1, 1, 32'hAA, 0);
    tv[6]  = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 1, 4, 0, 0,                 1, 1, 2, 32'h55, 0);
    tv[7]  = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 0, 4, 1, 0,                 1, 0, 2, 32'h55, 0);
    tv[8]  = mk(0, 0, 0,      2'b11, 3, 32'h1,    3, 32'h2,  2'b00, 0, 4, 1, 0,                 1, 0, 2, 32'h55, 0);
    tv[9]  = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 3, 4, 1, 32'h2,             0, 1, 3, 32'h2, 0);
    tv[10] = mk(1, 0, 32'h40, 2'b11, 5, 32'h77,   0, 32'h99, 2'b00, 0, 4, 1, 0,                 1, 0, 3, 32'h2, 0);
    tv[11] = mk(1, 1, 32'h50, 2'b01, 5, 32'hEE,   0, 0,      2'b00, 0, 5, 1, 0,                 2, 0, 3, 32'h2, 0);
    tv[12] = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 5, 6, 1, 32'h50,            2, 0, 3, 32'h2, 0);
    tv[13] = mk(0, 0, 0,      2'b10, 0, 0,        4, 32'h1234, 2'b10, 4, 6, BYP, BYP ? 32'h1234 : 32'h0, 2, 0, 3, 32'h2, 0);
    tv[14] = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 4, 6, 1, 32'h1234,          1, 1, 4, 32'h1234, 1);
    tv[15] = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 0, 6, 1, 0,                 0, 1, 5, 32'h50, 0);
    tv[16] = mk(1, 1, 32'h60, 2'b00, 0, 0,        0, 0,      2'b00, 0, 6, 1, 0,                 1, 0, 5, 32'h50, 0);
    tv[17] = mk(0, 0, 0,      2'b00, 0, 0,        0, 0,      2'b00, 0, 7, 1, 0,                 0, 1, 6, 32'h60, 0);

    do_reset();
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_disp_tag", 64'(bus.disp_tag), 64'd1);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("rst_commit_value", 64'(bus.commit_value), 64'd0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk($sformatf("v%0d_disp_tag", i), 64'(bus.disp_tag), 64'(tv[i].e_dtag));
      chk($sformatf("v%0d_src1_ready", i), 64'(bus.src1_ready), 64'(tv[i].e_sr));
      chk($sformatf("v%0d_src1_value", i), 64'(bus.src1_value), 64'(tv[i].e_sv));
      chk($sformatf("v%0d_src2_ready", i), 64'(bus.src2_ready), 64'(tv[i].e_sr));
      chk($sformatf("v%0d_src2_value", i), 64'(bus.src2_value), 64'(tv[i].e_sv));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 64'(bus.count), 64'(tv[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 64'(bus.empty), 64'(tv[i].e_cnt == 4'd0));
      chk($sformatf("v%0d_commit_valid", i), 64'(bus.commit_valid), 64'(tv[i].e_cv));
      chk($sformatf("v%0d_commit_tag", i), 64'(bus.commit_tag), 64'(tv[i].e_ctag));
      chk($sformatf("v%0d_commit_value", i), 64'(bus.commit_value), 64'(tv[i].e_cval));
      chk($sformatf("v%0d_commit_flag", i), 64'(bus.commit_flag), 64'(tv[i].e_cf));
    end

    // Fill to DEPTH, reject the overflow, then retire and wrap the tail to tag 1.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      idle();
      dispatch(32'h100 + 32'(i), 5'(i), 5'(i + 10));
      #1;
      chk($sformatf("fill%0d_disp_tag", i), 64'(bus.disp_tag), 64'(i));
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    #1;
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    chk("full_count", 64'(bus.count), 64'd8);
    dispatch(32'hDEAD, 5'd9, 5'd9);
    @(posedge clk); #1;
    chk("overflow_count", 64'(bus.count), 64'd8);
    chk("overflow_disp_tag", 64'(bus.disp_tag), 64'd1);
    @(negedge clk);
    idle();
    wb0(4'd1, 32'hC1);
    @(posedge clk); #1;
    chk("wb_head_count", 64'(bus.count), 64'd8);
    @(negedge clk);
    idle();
    dispatch(32'hBEEF, 5'd7, 5'd7);
    #1;
    chk("full_commit_disp_ready", 64'(bus.disp_ready), 64'd0);
    @(posedge clk); #1;
    chk("wrap_commit_valid", 64'(bus.commit_valid), 64'd1);
    chk("wrap_commit_tag", 64'(bus.commit_tag), 64'd1);
    chk("wrap_commit_value", 64'(bus.commit_value), 64'hC1);
    chk("wrap_commit_op", 64'(bus.commit_op), 64'd1);
    chk("wrap_commit_rd", 64'(bus.commit_rd), 64'd11);
    chk("wrap_commit_count", 64'(bus.count), 64'd7);
    @(negedge clk);
    idle();
    dispatch(32'h900, 5'd3, 5'd4);
    #1;
    chk("wrap_disp_tag", 64'(bus.disp_tag), 64'd1);
    @(posedge clk); #1;
    chk("wrap_count", 64'(bus.count), 64'd8);
    chk("wrap_full", 64'(bus.full), 64'd1);

    // Head becomes done, then flush collides with its commit, a dispatch and a writeback.
    @(negedge clk);
    idle();
    wb0(4'd2, 32'hC2);
    @(posedge clk);
    @(negedge clk);
    idle();
    bus.flush = 1'b1;
    dispatch(32'h77, 5'd1, 5'd1);
    wb0(4'd3, 32'hC3);
    @(posedge clk); #1;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_empty", 64'(bus.empty), 64'd1);
    chk("flush_disp_tag", 64'(bus.disp_tag), 64'd1);
    chk("flush_commit_valid", 64'(bus.commit_valid), 64'd0);
    @(negedge clk);
    idle();
    bus.src1_tag = 4'd2;
    #1;
    chk("flush_src1_ready", 64'(bus.src1_ready), 64'd0);
    @(posedge clk); #1;
    chk("post_flush_commit_valid", 64'(bus.commit_valid), 64'd0);
    chk("post_flush_count", 64'(bus.count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
